lsu: RTL

Load/store unit sitting directly upstream of the data memory `dmem` in the MIPS core's MEM stage. It accepts one load or store request at a time from the pipeline and performs all word and sub-word accesses (LB, LBU, LH, LHU, LW, SB, SH, SW) against the word-addressed `dmem`. Sub-word stores use a read-modify-write sequence. Alignment and range errors are flagged without touching memory. `busy` stalls the pipeline while an access is in flight.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 38 +++
 rtl/lsu.sv | 113 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op encodings,
// FSM states and the access-size decode helpers.
package lsu_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    // Access size lives in op[1:0]; op[2] selects zero extension, op[3] store.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
            default:             op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lane);
        case (op[1:0])
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = (lane != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extends a load out of the buffered word and merges
// sub-word store data into it for the read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rbuf,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lane,
    input  logic [3:0]  i_op,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_byte   = i_rbuf[{i_lane, 3'b000} +: 8];
        w_half   = i_rbuf[{i_lane[1], 4'b0000} +: 16];
        o_load   = i_rbuf;
        o_merged = i_wdata;
        case (i_op[1:0])
            SZ_BYTE: begin
                o_load   = i_op[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
                o_merged = i_rbuf;
                o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load   = i_op[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                o_merged = i_rbuf;
                o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of the word-addressed dmem: one request at a time,
// sub-word stores by read-modify-write, bad requests answered with err.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEMSIZE = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] dm_ad,
    output logic        dm_we,
    output logic [31:0] dm_wData,
    input  logic [31:0] dm_rData
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEMSIZE) << 2;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rbuf;
    logic        w_bad;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_bad = !op_legal(op) || misaligned(op, addr[1:0]) ||
                   ({1'b0, addr} >= ADDR_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rbuf  <= '0;
        end else begin
            if (r_state == IDLE && req) begin
                r_op    <= op;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (r_state == READ) r_rbuf <= dm_rData;
        end
    end

    lsu_align u_align (
        .i_rbuf   (r_rbuf),
        .i_wdata  (r_wdata),
        .i_lane   (r_addr[1:0]),
        .i_op     (r_op),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_comb begin
        w_next   = r_state;
        busy     = (r_state != IDLE);
        done     = 1'b0;
        err      = 1'b0;
        rdata    = '0;
        dm_ad    = '0;
        dm_we    = 1'b0;
        dm_wData = '0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_bad)            w_next = ERR;
                    else if (op == OP_SW) w_next = WRITE;
                    else                  w_next = READ;
                end
            end
            READ: begin
                dm_ad  = {r_addr[31:2], 2'b00};
                w_next = r_op[3] ? WRITE : RESP;
            end
            WRITE: begin
                dm_ad    = {r_addr[31:2], 2'b00};
                dm_we    = 1'b1;
                dm_wData = w_merged;
                done     = 1'b1;
                w_next   = IDLE;
            end
            RESP: begin
                dm_ad  = {r_addr[31:2], 2'b00};
                rdata  = w_load;
                done   = 1'b1;
                w_next = IDLE;
            end
            ERR: begin
                done   = 1'b1;
                err    = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
